// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word and RAM status types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter between fetch and data requests
// Data requests win over fetches; an access completes with a one-cycle hit pulse.
module memory_arbiter
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  ramstate_t ramstate,
    input  word_t     ramload,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q;
    logic       ihit_q;
    logic       dhit_q;
    word_t      iload_q;
    word_t      dload_q;
    logic       err_q;
    logic [1:0] retry_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
            err_q   <= 1'b0;
            retry_q <= 2'd0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dREN || dWEN) begin
                        state_q <= DATA;
                        retry_q <= 2'd0;
                    end else if (iREN) begin
                        state_q <= INSTR;
                        retry_q <= 2'd0;
                    end
                end
                DATA: begin
                    // A withdrawn request aborts before the RAM response is considered.
                    if (!(dREN || dWEN)) begin
                        state_q <= IDLE;
                    end else if (ramstate == ACCESS) begin
                        dhit_q  <= 1'b1;
                        state_q <= DONE;
                        if (!dWEN) begin
                            dload_q <= ramload;
                        end
                    end else if (ramstate == ERROR) begin
                        if (retry_q == 2'd2) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            retry_q <= retry_q + 2'd1;
                        end
                    end
                end
                INSTR: begin
                    if (!iREN) begin
                        state_q <= IDLE;
                    end else if (ramstate == ACCESS) begin
                        ihit_q  <= 1'b1;
                        iload_q <= ramload;
                        state_q <= DONE;
                    end else if (ramstate == ERROR) begin
                        if (retry_q == 2'd2) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            retry_q <= retry_q + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM strobes follow the live request so wait states see stable, current values.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            INSTR: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign ihit  = ihit_q;
    assign dhit  = dhit_q;
    assign iload = iload_q;
    assign dload = dload_q;
    assign err   = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      err;

    always #5 CLK = ~CLK;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramstate(ramstate), .ramload(ramload),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .err(err)
    );

    typedef struct {
        bit    is_i;
        word_t value;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    word_t m_iload = '0;
    word_t m_dload = '0;
    bit    m_err   = 1'b0;
    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    last_ihit_cyc = 0;
    int    last_dhit_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: every hit pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (ihit === 1'b1 || dhit === 1'b1) begin
            chk("hit_exclusive", {31'b0, ihit & dhit}, 32'd0);
            if (ihit === 1'b1) last_ihit_cyc = cyc;
            if (dhit === 1'b1) last_dhit_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_hit", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hit_kind", {31'b0, ihit}, {31'b0, mon_e.is_i});
                if (mon_e.is_i) chk("iload", iload, mon_e.value);
                else            chk("dload", dload, mon_e.value);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_data(input bit on);
        int r;
        if (on) begin
            r      = $urandom_range(1, 3);
            dREN   = r[0];
            dWEN   = r[1];
            daddr  = $urandom;
            dstore = $urandom;
        end else begin
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    task automatic set_instr(input bit on);
        iREN = on;
        if (on) iaddr = $urandom;
    endtask

    // mode 0: no access expected, 1: data access, 2: fetch
    task automatic chk_strobes(input string tag, input int mode);
        logic  e_ren, e_wen;
        word_t e_addr, e_store;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        if (mode == 1) begin
            e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN & ~dWEN;
        end else if (mode == 2) begin
            e_addr = iaddr; e_ren = 1'b1;
        end
        chk({tag, ".ramREN"},  {31'b0, ramREN}, {31'b0, e_ren});
        chk({tag, ".ramWEN"},  {31'b0, ramWEN}, {31'b0, e_wen});
        chk({tag, ".ramaddr"}, ramaddr, e_addr);
        if (mode != 2) chk({tag, ".ramstore"}, ramstore, e_store);
    endtask

    // Caller has the request asserted with the DUT in IDLE. term 0: ACCESS, 1: third ERROR, 2: withdraw.
    task automatic do_txn(input bit is_data, input int nwait, input bit busy_only, input int nerr,
                          input int term, input word_t rdata, input bit raise_data);
        int mode;
        mode = is_data ? 1 : 2;
        tick();
        if (raise_data) set_data(1'b1);
        for (int k = 0; k < nwait + nerr; k++) begin
            chk_strobes("wait", mode);
            if (k < nwait) ramstate = (busy_only || $urandom_range(0, 1) == 1) ? BUSY : FREE;
            else           ramstate = ERROR;
            ramload = $urandom;
            tick();
        end
        chk_strobes("final", mode);
        ramload = rdata;
        if (term == 0) begin
            ramstate = ACCESS;
            if (is_data) begin
                if (!dWEN) m_dload = rdata;
                exp_q.push_back('{is_i: 1'b0, value: m_dload});
            end else begin
                m_iload = rdata;
                exp_q.push_back('{is_i: 1'b1, value: m_iload});
            end
            tick();
            chk("hit_latency", {31'b0, is_data ? dhit : ihit}, 32'd1);
            chk_strobes("done", 0);
        end else begin
            if (term == 1) begin
                ramstate = ERROR;
                m_err    = 1'b1;
            end else begin
                ramstate = ACCESS;
                if (is_data) set_data(1'b0);
                else         iREN = 1'b0;
            end
            tick();
            chk("no_hit", {30'b0, ihit, dhit}, 32'd0);
            chk("err_now", {31'b0, err}, {31'b0, m_err});
            chk_strobes("abandon", 0);
        end
        ramstate = FREE;
    endtask

    task automatic finish_txn(input int term);
        if (term == 0) begin
            tick();
            chk_strobes("idle_after_done", 0);
        end
        set_data(1'b0);
        set_instr(1'b0);
        ramstate = FREE;
        tick();
        chk("err_model", {31'b0, err}, {31'b0, m_err});
        chk("iload_hold", iload, m_iload);
        chk("dload_hold", dload, m_dload);
    endtask

    // first_data=1: both requests collide; first_data=0: data arrives mid-fetch.
    task automatic do_pair(input bit first_data, input int t1, input int w1, input int e1,
                           input int t2, input int w2, input int e2);
        if (first_data) begin
            set_data(1'b1);
            set_instr(1'b1);
        end else begin
            set_instr(1'b1);
        end
        do_txn(first_data, w1, 1'b0, e1, t1, $urandom, !first_data);
        if (first_data) set_data(1'b0);
        else            iREN = 1'b0;
        if (t1 == 0) begin
            tick();
            chk_strobes("pair_idle", 0);
        end
        do_txn(!first_data, w2, 1'b0, e2, t2, $urandom, 1'b0);
        finish_txn(t2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".hits"},  {30'b0, ihit, dhit}, 32'd0);
        chk({tag, ".iload"}, iload, 32'd0);
        chk({tag, ".dload"}, dload, 32'd0);
        chk({tag, ".err"},   {31'b0, err}, 32'd0);
        chk_strobes(tag, 0);
    endtask

    task automatic reset_mid(input bit is_data, input int nwait);
        if (is_data) set_data(1'b1);
        else         set_instr(1'b1);
        tick();
        for (int k = 0; k < nwait; k++) begin
            ramstate = BUSY;
            tick();
        end
        nRST     = 1'b0;
        ramstate = ACCESS;
        ramload  = $urandom;
        tick();
        m_iload = '0;
        m_dload = '0;
        m_err   = 1'b0;
        chk_all_zero("reset_mid");
        nRST = 1'b1;
        set_data(1'b0);
        set_instr(1'b0);
        ramstate = FREE;
        tick();
    endtask

    task automatic pick(output int term, output int nwait, output int nerr);
        int r;
        r     = $urandom_range(0, 99);
        term  = (r < 70) ? 0 : (r < 85) ? 1 : 2;
        nwait = $urandom_range(0, 3);
        nerr  = (term == 1) ? 2 : $urandom_range(0, 2);
    endtask

    initial begin
        int t1, w1, e1, t2, w2, e2, sc;
        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramstate = FREE; ramload = '0;
        tick();
        tick();
        chk_all_zero("reset");
        nRST = 1'b1;
        tick();

        // Fetch with immediate ACCESS
        iREN = 1'b1; iaddr = 32'h0000_0040;
        do_txn(1'b0, 0, 1'b0, 0, 0, 32'h2001_0005, 1'b0);
        finish_txn(0);
        chk("fetch_iload", iload, 32'h2001_0005);

        // Write/fetch collision: write first, fetch three cycles later
        iREN = 1'b1; iaddr = 32'h0000_0200;
        dREN = 1'b0; dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        do_txn(1'b1, 0, 1'b0, 0, 0, 32'h5555_0000, 1'b0);
        dWEN = 1'b0;
        tick();
        chk_strobes("coll_idle", 0);
        do_txn(1'b0, 0, 1'b0, 0, 0, 32'h0BAD_F00D, 1'b0);
        finish_txn(0);
        chk("hit_spacing", {31'b0, (last_ihit_cyc - last_dhit_cyc) >= 3}, 32'd1);

        // Four busy cycles then ACCESS on a read
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h0000_0080; dstore = 32'h0;
        do_txn(1'b1, 4, 1'b1, 0, 0, 32'h1234_5678, 1'b0);
        finish_txn(0);
        chk("wait_dload", dload, 32'h1234_5678);

        // Three errors on a fetch, then err must persist across a good fetch
        set_instr(1'b1);
        do_txn(1'b0, 0, 1'b0, 2, 1, $urandom, 1'b0);
        finish_txn(1);
        set_instr(1'b1);
        do_txn(1'b0, 1, 1'b0, 0, 0, $urandom, 1'b0);
        finish_txn(0);
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Withdrawn fetch, then reset during ACCESS
        set_instr(1'b1);
        do_txn(1'b0, 1, 1'b0, 0, 2, $urandom, 1'b0);
        finish_txn(2);
        reset_mid(1'b0, 0);

        for (int n = 0; n < 300; n++) begin
            sc = $urandom_range(0, 9);
            pick(t1, w1, e1);
            pick(t2, w2, e2);
            if (sc <= 4) begin
                if (sc[0]) set_data(1'b1);
                else       set_instr(1'b1);
                do_txn(sc[0], w1, 1'b0, e1, t1, $urandom, 1'b0);
                finish_txn(t1);
            end else if (sc <= 6) begin
                do_pair(1'b1, t1, w1, e1, t2, w2, e2);
            end else if (sc <= 8) begin
                do_pair(1'b0, t1, w1, e1, t2, w2, e2);
            end else begin
                reset_mid(sc[0], $urandom_range(0, 2));
            end
        end

        tick();
        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
